// File: rtl/dac_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, its register writer and the
// serial DAC transmitter.
//   wr_en/wr_ch/wr_data : shadow register write port
//   update              : frame commit request (1-cycle pulse)
//   frame_busy          : frame in progress
//   frame_done          : 1-cycle pulse at end of frame
//   dac_start/dac_data  : word hand-off to the transmitter
//   dac_busy            : transmitter busy
//   ldac_n              : active-low load strobe to the DAC
//   err_timeout         : sticky transmitter acknowledge timeout
// master: the environment (writer + transmitter). slave: the sequencer.
interface dac_frame_sequencer_if #(
  parameter int unsigned CH_W   = 3,
  parameter int unsigned DATA_W = 12
);
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              update;
  logic              frame_busy;
  logic              frame_done;
  logic              dac_start;
  logic [15:0]       dac_data;
  logic              dac_busy;
  logic              ldac_n;
  logic              err_timeout;

  modport master (
    output wr_en, wr_ch, wr_data, update, dac_busy,
    input  frame_busy, frame_done, dac_start, dac_data, ldac_n, err_timeout
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, update, dac_busy,
    output frame_busy, frame_done, dac_start, dac_data, ldac_n, err_timeout
  );
endinterface

// File: rtl/dac_frame_sequencer.sv
// Multi-channel update scheduler in front of a single serial DAC transmitter.
// Keeps one shadow code per channel plus a dirty mask; on a frame commit it
// snapshots the dirty channels, sends each one in ascending order through the
// transmitter's start/busy handshake, then pulses ldac_n so every DAC output
// updates together.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dac_frame_sequencer_if.slave (write port, commit, status,
//              transmitter handshake, ldac_n, err_timeout)
module dac_frame_sequencer #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LDAC_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dac_frame_sequencer_if.slave   bus
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam int unsigned     TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam int unsigned     LD_W    = $clog2(LDAC_W + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(LDAC_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH,
    S_LDAC,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shadow     [NUM_CH];
  logic [DATA_W-1:0] frame_data [NUM_CH];
  logic [NUM_CH-1:0] dirty;
  logic [NUM_CH-1:0] frame_mask;
  logic [NUM_CH-1:0] wr_hit;
  logic [CH_W-1:0]   idx;
  logic [TO_W-1:0]   tcnt;
  logic [LD_W-1:0]   lcnt;
  logic              sent_any;
  logic              wr_ok;
  logic              accept;

  logic              frame_busy_q;
  logic              frame_done_q;
  logic              dac_start_q;
  logic [15:0]       dac_data_q;
  logic              ldac_n_q;
  logic              err_timeout_q;

  assign wr_ok  = bus.wr_en && (32'(bus.wr_ch) < NUM_CH);
  assign accept = bus.update && (state == S_IDLE);

  always_comb begin
    wr_hit = '0;
    if (wr_ok) begin
      wr_hit[bus.wr_ch] = 1'b1;
    end
  end

  // Shadow file and dirty mask. A write landing in the accept cycle is not
  // part of the snapshot, so its dirty bit survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
      end
      dirty <= '0;
    end else begin
      if (wr_ok) begin
        shadow[bus.wr_ch] <= bus.wr_data;
      end
      dirty <= (accept ? '0 : dirty) | wr_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      frame_mask    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        frame_data[i] <= '0;
      end
      tcnt          <= '0;
      lcnt          <= '0;
      sent_any      <= 1'b0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      dac_start_q   <= 1'b0;
      dac_data_q    <= '0;
      ldac_n_q      <= 1'b1;
      err_timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.update) begin
            frame_mask   <= dirty;
            frame_data   <= shadow;
            idx          <= '0;
            sent_any     <= 1'b0;
            frame_busy_q <= 1'b1;
            state        <= S_SCAN;
          end
        end

        // dac_start is raised on entry so it is high exactly while in START.
        S_SCAN: begin
          if (frame_mask[idx]) begin
            dac_start_q <= 1'b1;
            dac_data_q  <= {4'(idx), frame_data[idx]};
            sent_any    <= 1'b1;
            state       <= S_START;
          end else if (idx == LAST_CH) begin
            state <= S_FINISH;
          end else begin
            idx <= idx + CH_W'(1);
          end
        end

        S_START: begin
          dac_start_q <= 1'b0;
          tcnt        <= '0;
          state       <= S_WAIT_ACK;
        end

        // busy is sampled before the limit test, so busy arriving on the
        // ACK_TIMEOUT-th cycle after start is still accepted.
        S_WAIT_ACK: begin
          if (bus.dac_busy) begin
            state <= S_WAIT_DONE;
          end else if (tcnt == TO_LAST) begin
            err_timeout_q <= 1'b1;
            state         <= S_NEXT;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!bus.dac_busy) begin
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          frame_mask[idx] <= 1'b0;
          if (idx == LAST_CH) begin
            state <= S_FINISH;
          end else begin
            idx   <= idx + CH_W'(1);
            state <= S_SCAN;
          end
        end

        // The empty-frame path reuses DONE as its one-cycle frame_done tail.
        S_FINISH: begin
          if (sent_any) begin
            ldac_n_q <= 1'b0;
            lcnt     <= '0;
            state    <= S_LDAC;
          end else begin
            frame_done_q <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_LDAC: begin
          if (lcnt == LD_LAST) begin
            ldac_n_q     <= 1'b1;
            frame_done_q <= 1'b1;
            state        <= S_DONE;
          end else begin
            lcnt <= lcnt + LD_W'(1);
          end
        end

        S_DONE: begin
          frame_done_q <= 1'b0;
          frame_busy_q <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.frame_busy  = frame_busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.dac_start   = dac_start_q;
  assign bus.dac_data    = dac_data_q;
  assign bus.ldac_n      = ldac_n_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Scoreboard bench for dac_frame_sequencer: stimulus updates a channel-level
// model and queues the expected words and frame outcomes; a monitor checks
// every dac_start, ldac_n pulse and frame_done against those queues. A
// transmitter model answers dac_start with fixed, random or no busy response.
module tb_dac_frame_sequencer;
  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned DATA_W      = 12;
  localparam int unsigned LDAC_W      = 4;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dac_frame_sequencer_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  dac_frame_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
    .LDAC_W(LDAC_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int nwords; int t_acc; } frame_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] m_shadow [NUM_CH];
  bit                m_dirty  [NUM_CH];
  bit                m_busy;
  logic [15:0]       exp_words[$];
  frame_t            exp_frames[$];

  bit tx_stuck = 1'b0;
  bit tx_rand  = 1'b0;
  int tx_delay = 2;
  int tx_hold  = 3;

  int words_seen, ldac_pulses, ldac_len, last_start, err_exp;
  bit ldac_prev, chk_fb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b0;
    end
    m_busy = 1'b0;
    exp_words.delete();
    exp_frames.delete();
    words_seen = 0; ldac_pulses = 0; ldac_len = 0; last_start = 0;
    err_exp = 0; ldac_prev = 1'b1; chk_fb = 1'b0;
  endtask

  // One input cycle; entered and left just after a rising edge.
  task automatic drive(input bit we, input int ch, input logic [DATA_W-1:0] d, input bit upd);
    frame_t f;
    if (upd && !m_busy) begin
      f.nwords = 0;
      f.t_acc  = cyc;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_dirty[c]) begin
          exp_words.push_back({4'(c), m_shadow[c]});
          f.nwords++;
          m_dirty[c] = 1'b0;
        end
      end
      exp_frames.push_back(f);
      m_busy = 1'b1;
    end
    if (we && ch < NUM_CH) begin
      m_shadow[ch] = d;
      m_dirty[ch]  = 1'b1;
    end
    bus.wr_en   = we;
    bus.wr_ch   = CH_W'(ch);
    bus.wr_data = d;
    bus.update  = upd;
    @(posedge clk); #1;
    bus.wr_en  = 1'b0;
    bus.update = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (m_busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy) begin
      chk("frame_complete_timeout", 0, 1);
      m_busy = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: busy rises d cycles after the start cycle, holds h cycles.
  initial begin
    int d, h;
    bus.dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dac_start && !tx_stuck && !rst) begin
        d = tx_rand ? int'($urandom_range(1, ACK_TIMEOUT)) : tx_delay;
        h = tx_rand ? int'($urandom_range(1, 4)) : tx_hold;
        repeat (d) @(posedge clk);
        #1 bus.dac_busy = 1'b1;
        repeat (h) @(posedge clk);
        #1 bus.dac_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    frame_t f;
    @(negedge clk);
    if (!rst) begin
      if (chk_fb) begin
        chk("frame_busy_after_done", bus.frame_busy, 0);
        chk_fb = 1'b0;
      end
      if (bus.dac_start) begin
        chk("start_while_busy", bus.dac_busy, 0);
        if (words_seen > 0) chk("start_spacing", (cyc - last_start) >= 3, 1);
        last_start = cyc;
        if (exp_words.size() == 0) chk("unexpected_start", bus.dac_data, 16'hFFFF);
        else chk("dac_data", bus.dac_data, exp_words.pop_front());
        words_seen++;
        if (tx_stuck && !bus.err_timeout) err_exp = cyc + ACK_TIMEOUT + 1;
      end
      if (err_exp > 0) begin
        if (cyc == err_exp - 1) chk("err_timeout_early", bus.err_timeout, 0);
        else if (cyc == err_exp) begin
          chk("err_timeout_set", bus.err_timeout, 1);
          err_exp = 0;
        end
      end
      if (!bus.ldac_n) begin
        if (ldac_prev) begin
          chk("ldac_while_busy", bus.dac_busy, 0);
          chk("ldac_words_left", exp_words.size(), 0);
        end
        ldac_len++;
      end else if (!ldac_prev) begin
        chk("ldac_width", ldac_len, LDAC_W);
        ldac_pulses++;
        ldac_len = 0;
      end
      ldac_prev = bus.ldac_n;
      if (bus.frame_done) begin
        if (exp_frames.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          f = exp_frames.pop_front();
          chk("frame_words", words_seen, f.nwords);
          chk("frame_ldac_pulses", ldac_pulses, (f.nwords > 0) ? 1 : 0);
          if (f.nwords == 0) chk("empty_frame_latency", (cyc - f.t_acc) <= int'(NUM_CH + 3), 1);
          chk("frame_busy_at_done", bus.frame_busy, 1);
        end
        words_seen  = 0;
        ldac_pulses = 0;
        m_busy      = 1'b0;
        chk_fb      = 1'b1;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.update = 1'b0;
    rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_frame_busy", bus.frame_busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_dac_start", bus.dac_start, 0);
    chk("rst_dac_data", bus.dac_data, 0);
    chk("rst_ldac_n", bus.ldac_n, 1);
    chk("rst_err_timeout", bus.err_timeout, 0);
    @(posedge clk); #1;

    // Two channels, expect 0x2123 then 0x5ABC.
    drive(1, 2, 12'h123, 0);
    drive(1, 5, 12'hABC, 0);
    drive(0, 0, '0, 1);
    wait_frame();

    // Empty frame.
    drive(0, 0, '0, 1);
    wait_frame();

    // Write in the accept cycle stays for the next frame.
    drive(1, 0, 12'h5A5, 0);
    drive(1, 1, 12'h777, 1);
    wait_frame();
    drive(0, 0, '0, 1);
    wait_frame();

    // Update during a frame is dropped; the mid-frame write goes next time.
    drive(1, 4, 12'h444, 0);
    drive(0, 0, '0, 1);
    repeat (3) drive(0, 0, '0, 0);
    chk("frame_busy_mid_frame", bus.frame_busy, 1);
    drive(1, 6, 12'h666, 0);
    drive(0, 0, '0, 1);
    wait_frame();
    drive(0, 0, '0, 1);
    wait_frame();

    // Randomized frames with random acknowledge delays.
    tx_rand = 1'b1;
    repeat (25) begin
      n = int'($urandom_range(0, 5));
      repeat (n) drive(1, int'($urandom_range(0, NUM_CH - 1)), DATA_W'($urandom), 0);
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, NUM_CH - 1)), DATA_W'($urandom), 1);
      wait_frame();
    end
    tx_rand = 1'b0;

    // Stuck transmitter: timeout, frame still completes with ldac.
    tx_stuck = 1'b1;
    drive(1, 3, 12'h333, 0);
    drive(0, 0, '0, 1);
    wait_frame();
    tx_stuck = 1'b0;
    chk("err_sticky_after_frame", bus.err_timeout, 1);
    drive(1, 7, 12'h7E7, 0);
    drive(0, 0, '0, 1);
    wait_frame();
    chk("err_sticky_next_frame", bus.err_timeout, 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared_by_rst", bus.err_timeout, 0);
    @(posedge clk); #1;

    // Reset while the transmitter is busy (WAIT_DONE).
    tx_hold = 6;
    drive(1, 1, 12'h111, 0);
    drive(1, 2, 12'h222, 0);
    drive(0, 0, '0, 1);
    n = 0;
    while (!bus.dac_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_before_reset", bus.dac_busy, 1);
    do_reset();
    @(negedge clk);
    chk("abort_ldac_n", bus.ldac_n, 1);
    chk("abort_frame_busy", bus.frame_busy, 0);
    chk("abort_dac_start", bus.dac_start, 0);
    @(posedge clk); #1;
    drive(0, 0, '0, 1);
    wait_frame();
    tx_hold = 3;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
